// File: rtl/data_ram_if.sv
// Bus between the write-control stage and the MEM-stage data RAM.
// master drives the requests; slave is the RAM side.
interface data_ram_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
);
    logic              stall;
    logic              rw_enable;
    logic [ADDR_W-1:0] data_addr;
    logic [ADDR_W-1:0] ram_w_addr;
    logic [DATA_W-1:0] ram_w_data;
    logic [DATA_W-1:0] r_data;
    logic              ram_busy;
    logic [CNT_W-1:0]  store_cnt;

    modport master (
        output stall, rw_enable, data_addr, ram_w_addr, ram_w_data,
        input  r_data, ram_busy, store_cnt
    );

    modport slave (
        input  stall, rw_enable, data_addr, ram_w_addr, ram_w_data,
        output r_data, ram_busy, store_cnt
    );
endinterface

// File: rtl/data_ram.sv
// 256 x 8 MEM-stage data RAM: registered read, write-through store, saturating store counter.
// Define DATA_RAM_CLEAR_EN to zero the array after every reset (RAM_BUSY high while clearing).
module data_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned CNT_W  = 16
) (
    input logic        clk,
    input logic        rst,
    data_ram_if.slave  bus
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic              store_go;
    logic              load_go;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] r_data_q;
    logic [CNT_W-1:0]  store_cnt_q;

`ifdef DATA_RAM_CLEAR_EN
    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              clr_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StClear;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_we  = 1'b0;
        unique case (state_q)
            StClear: begin
                clr_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: state_d = StClear;
        endcase
    end

    assign run          = (state_q == StRun);
    assign bus.ram_busy = ~run;
`else
    assign run          = 1'b1;
    assign bus.ram_busy = 1'b0;
`endif

    // Reset takes priority over any pending request.
    assign store_go = ~rst & run & ~bus.stall & bus.rw_enable;
    assign load_go  = ~rst & run & ~bus.stall & ~bus.rw_enable;

    always_comb begin
        mem_we    = store_go;
        mem_waddr = bus.ram_w_addr;
        mem_wdata = bus.ram_w_data;
`ifdef DATA_RAM_CLEAR_EN
        if (!run) begin
            mem_we    = clr_we & ~rst;
            mem_waddr = ptr_q;
            mem_wdata = '0;
        end
`endif
    end

    // Array has no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q <= '0;
        end else if (store_go) begin
            r_data_q <= bus.ram_w_data;
        end else if (load_go) begin
            r_data_q <= mem[bus.data_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            store_cnt_q <= '0;
        end else if (store_go && (store_cnt_q != '1)) begin
            store_cnt_q <= store_cnt_q + 1'b1;
        end
    end

    assign bus.r_data    = r_data_q;
    assign bus.store_cnt = store_cnt_q;

endmodule
